grid_tick_sequencer: RTL and testbench



---
 rtl/snn_seq_pkg.sv | 16 +
 rtl/seq_watchdog.sv | 23 ++
 rtl/grid_tick_sequencer.sv | 113 +++++++++++
 tb/tb_grid_tick_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_seq_pkg.sv
// Shared state encoding and fault cause codes for the grid tick sequencer.
package snn_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_GRID     = 2'd2;
  localparam logic [1:0] ERR_SPURIOUS = 2'd3;
endpackage

// File: rtl/seq_watchdog.sv
// Loadable down-counter; expired fires on the decrement that would reach zero.
module seq_watchdog #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            load,
  input  logic            dec,
  input  logic [TO_W-1:0] load_val,
  output logic            expired
);
  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)                    cnt <= '0;
    else if (load)                   cnt <= load_val;
    else if (en && dec && cnt != '0) cnt <= cnt - TO_W'(1);
  end

  // Firing on the 1->0 step makes FAULT follow exactly load_val WAIT cycles.
  assign expired = en && dec && (cnt == TO_W'(1));
endmodule

// File: rtl/grid_tick_sequencer.sv
// Timestep scheduler: ticks each grid in order, waits for its done, repeats
// for num_timesteps, and parks in a sticky FAULT on error/timeout/stray done.
module grid_tick_sequencer
  import snn_seq_pkg::*;
#(
  parameter int NUM_GRIDS = 4,
  parameter int GIDX_W    = 2,
  parameter int TS_W      = 16,
  parameter int TO_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 clear_error,
  input  logic [TS_W-1:0]      num_timesteps,
  input  logic [TO_W-1:0]      timeout_cycles,
  input  logic [NUM_GRIDS-1:0] grid_done,
  input  logic [NUM_GRIDS-1:0] grid_error,
  output logic [NUM_GRIDS-1:0] grid_tick,
  output logic                 busy,
  output logic [GIDX_W-1:0]    active_grid,
  output logic [TS_W-1:0]      timestep,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code
);
  seq_state_t state, state_nxt;

  logic [GIDX_W-1:0]    ag;
  logic [TS_W-1:0]      ts, num_lat;
  logic [TO_W-1:0]      to_lat;
  logic [1:0]           ec;
  logic [NUM_GRIDS-1:0] sel;
  logic [TS_W:0]        ts_inc;
  logic                 my_done, my_err, other_done, last_grid, ts_last;
  logic                 wd_dec, wd_exp;

  assign sel        = NUM_GRIDS'(1) << ag;
  assign my_done    = |(grid_done & sel);
  assign my_err     = |(grid_error & sel);
  assign other_done = |(grid_done & ~sel);
  assign last_grid  = (ag == GIDX_W'(NUM_GRIDS-1));
  // Full-width compare so a maximum-count run never wraps.
  assign ts_inc     = {1'b0, ts} + {{TS_W{1'b0}}, 1'b1};
  assign ts_last    = (ts_inc == {1'b0, num_lat});
  assign wd_dec     = (state == ST_WAIT) && !abort && !my_err && !my_done && !other_done;

  seq_watchdog #(.TO_W(TO_W)) u_wd (
    .clk(clk), .reset_n(reset_n), .en(to_lat != '0), .load(state == ST_ISSUE),
    .dec(wd_dec), .load_val(to_lat), .expired(wd_exp)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (num_timesteps != '0) ? ST_ISSUE : ST_FINISH;
      ST_ISSUE:  state_nxt = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort)           state_nxt = ST_IDLE;
        else if (my_err)     state_nxt = ST_FAULT;
        else if (my_done)    state_nxt = ST_NEXT;
        else if (other_done) state_nxt = ST_FAULT;
        else if (wd_exp)     state_nxt = ST_FAULT;
      end
      ST_NEXT:   state_nxt = abort ? ST_IDLE : ((last_grid && ts_last) ? ST_FINISH : ST_ISSUE);
      ST_FINISH: state_nxt = ST_IDLE;
      ST_FAULT:  if (clear_error) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ag <= '0; ts <= '0; num_lat <= '0; to_lat <= '0; ec <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE: if (start && num_timesteps != '0) begin
          num_lat <= num_timesteps; to_lat <= timeout_cycles; ag <= '0; ts <= '0;
        end
        ST_WAIT: if (!abort) begin
          if (my_err)                     ec <= ERR_GRID;
          else if (!my_done && other_done) ec <= ERR_SPURIOUS;
          else if (!my_done && wd_exp)     ec <= ERR_TIMEOUT;
        end
        ST_NEXT: if (!abort) begin
          if (!last_grid)   ag <= ag + GIDX_W'(1);
          else begin
            ag <= '0;
            if (!ts_last) ts <= ts_inc[TS_W-1:0];
          end
        end
        ST_FAULT: if (clear_error) ec <= ERR_NONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    grid_tick   = (state == ST_ISSUE) ? sel : '0;
    busy        = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_NEXT) || (state == ST_FINISH);
    done        = (state == ST_FINISH);
    error       = (state == ST_FAULT);
    err_code    = ec;
    active_grid = ag;
    timestep    = ts;
  end
endmodule

// File: tb/tb_grid_tick_sequencer.sv
// Bench: timestamp-based reference model checked every cycle, plus directed
// scenarios with hand-computed cycle expectations.
module tb_grid_tick_sequencer;
  localparam int NG = 4;

  logic clk = 1'b0;
  logic reset_n, start, abort, clear_error;
  logic [15:0] num_timesteps, timeout_cycles;
  logic [NG-1:0] grid_done, grid_error, grid_tick;
  logic [NG-1:0] resp_done = '0, resp_err = '0, inj_done = '0;
  logic busy, done, error;
  logic [1:0] active_grid, err_code;
  logic [15:0] timestep;

  assign grid_done  = resp_done | inj_done;
  assign grid_error = resp_err;

  grid_tick_sequencer #(.NUM_GRIDS(NG), .GIDX_W(2), .TS_W(16), .TO_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .clear_error(clear_error),
    .num_timesteps(num_timesteps), .timeout_cycles(timeout_cycles),
    .grid_done(grid_done), .grid_error(grid_error), .grid_tick(grid_tick),
    .busy(busy), .active_grid(active_grid), .timestep(timestep), .done(done),
    .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: tracks when the current grid was ticked and when the
  // run ends, and derives every output from those timestamps.
  bit m_run = 0, m_fault = 0, m_got = 0;
  int m_code = 0, m_g = 0, m_ts = 0, m_n = 0, m_to = 0;
  int m_tick = -1, m_fin = -1;

  task automatic m_trip(input int code);
    m_run = 0; m_fault = 1; m_code = code; m_tick = -1; m_fin = -1;
  endtask

  always @(posedge clk) begin
    int c;
    c = cyc;
    if (!reset_n) begin
      m_run = 0; m_fault = 0; m_got = 0; m_code = 0; m_g = 0; m_ts = 0;
      m_n = 0; m_to = 0; m_tick = -1; m_fin = -1;
    end else if (m_fault) begin
      if (clear_error) begin m_fault = 0; m_code = 0; end
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_got = 0;
        if (num_timesteps == 0) m_fin = c + 1;
        else begin
          m_n = int'(num_timesteps); m_to = int'(timeout_cycles);
          m_g = 0; m_ts = 0; m_tick = c + 1;
        end
      end
    end else if (abort || c == m_fin) begin
      m_run = 0; m_fin = -1; m_tick = -1; m_got = 0;
    end else if (m_got) begin
      m_got = 0;
      if (m_g < NG - 1) begin m_g++; m_tick = c + 1; end
      else begin
        m_g = 0;
        if (m_ts + 1 == m_n) begin m_fin = c + 1; m_tick = -1; end
        else begin m_ts++; m_tick = c + 1; end
      end
    end else if (m_tick >= 0 && c > m_tick) begin
      if (grid_error[m_g])                         m_trip(2);
      else if (grid_done[m_g])                     m_got = 1;
      else if ((grid_done & ~(4'b1 << m_g)) != 0)  m_trip(3);
      else if (m_to != 0 && c - m_tick == m_to)    m_trip(1);
    end
    cyc = c + 1;
  end

  always @(negedge clk) begin
    logic [3:0] e_tick;
    e_tick = (m_run && m_tick == cyc) ? 4'(4'b1 << m_g) : 4'b0;
    check("outputs",
      {grid_tick, busy, active_grid, timestep, done, error, err_code},
      {e_tick, m_run, 2'(m_g), 16'(m_ts), (m_run && m_fin == cyc), m_fault, 2'(m_code)});
  end

  // Grid responders: done (optionally with error) lat cycles after the tick.
  int lat[NG] = '{0, 0, 0, 0};
  int due[NG] = '{-1, -1, -1, -1};
  logic [NG-1:0] err_mask = '0;
  always @(negedge clk) begin
    for (int i = 0; i < NG; i++) begin
      resp_done[i] = 1'b0; resp_err[i] = 1'b0;
      if (!reset_n) due[i] = -1;
      else begin
        if (due[i] == cyc) begin resp_done[i] = 1'b1; resp_err[i] = err_mask[i]; due[i] = -1; end
        if (grid_tick[i] && lat[i] != 0) due[i] = cyc + lat[i];
      end
    end
  end

  int tick_t[$], tick_v[$], tick_ts[$], done_t[$], err_t[$];
  always @(negedge clk) begin
    if (grid_tick != 0) begin tick_t.push_back(cyc); tick_v.push_back(int'(grid_tick)); tick_ts.push_back(int'(timestep)); end
    if (done) done_t.push_back(cyc);
    if (error) err_t.push_back(cyc);
  end

  task automatic step();
    @(negedge clk); #1;
  endtask
  task automatic clear_logs();
    tick_t.delete(); tick_v.delete(); tick_ts.delete(); done_t.delete(); err_t.delete();
  endtask
  task automatic kick(input int n, input int to, output int t0);
    num_timesteps = 16'(n); timeout_cycles = 16'(to); start = 1'b1; t0 = cyc;
    step(); start = 1'b0;
  endtask
  task automatic wait_for(input int what, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if ((what == 0 && done) || (what == 1 && error) || (what == 2 && grid_tick[1])) ok = 1;
      else step();
    end
  endtask
  task automatic do_clear();
    clear_error = 1'b1; step(); clear_error = 1'b0;
  endtask

  initial begin
    int t0;
    bit ok;
    int n;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; clear_error = 1'b0;
    num_timesteps = '0; timeout_cycles = '0;
    repeat (3) step();
    check("rst_busy", busy, 1'b0);
    check("rst_tick", grid_tick, 4'b0);
    check("rst_errcode", err_code, 2'd0);
    reset_n = 1'b1; step();

    // Normal run: 4 grids x 2 timesteps, done 5 cycles after each tick.
    lat = '{5, 5, 5, 5}; clear_logs();
    kick(2, 0, t0);
    wait_for(0, 120, ok);
    check("run_done_seen", ok, 1'b1);
    check("run_tick_count", tick_t.size(), 8);
    n = (tick_t.size() < 8) ? tick_t.size() : 8;
    for (int i = 0; i < n; i++) begin
      check("run_tick_time", tick_t[i] - t0, 1 + 7 * i);
      check("run_tick_grid", tick_v[i], 1 << (i % 4));
    end
    if (n > 4) check("run_ts_second_pass", tick_ts[4], 1);
    if (done_t.size() > 0) check("run_done_time", done_t[0] - t0, 57);
    step();
    check("run_busy_after", busy, 1'b0);
    check("run_done_once", done_t.size(), 1);

    // Watchdog: grid 0 never answers, timeout 10.
    lat = '{0, 0, 0, 0}; clear_logs();
    kick(1, 10, t0);
    wait_for(1, 40, ok);
    check("to_fault_seen", ok, 1'b1);
    if (err_t.size() > 0) check("to_fault_time", err_t[0] - t0, 12);
    check("to_code", err_code, 2'd1);
    do_clear();
    check("to_clear_err", error, 1'b0);
    check("to_clear_code", err_code, 2'd0);

    // Grid error coincident with grid 2's done.
    lat = '{3, 3, 3, 3}; err_mask = 4'b0100; clear_logs();
    kick(1, 0, t0);
    wait_for(1, 60, ok);
    check("ge_fault_seen", ok, 1'b1);
    check("ge_code", err_code, 2'd2);
    repeat (3) step();
    check("ge_tick_count", tick_t.size(), 3);
    check("ge_no_grid3", tick_v.size() > 0 ? tick_v[tick_v.size()-1] : 0, 4);
    do_clear(); err_mask = '0;

    // Spurious done from grid 3 while grid 1 is waiting.
    lat = '{3, 0, 0, 0}; clear_logs();
    kick(1, 0, t0);
    wait_for(2, 40, ok);
    check("sp_tick1_seen", ok, 1'b1);
    step(); step();
    inj_done = 4'b1000; step(); inj_done = '0;
    check("sp_error", error, 1'b1);
    check("sp_code", err_code, 2'd3);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    check("sp_start_ignored", {error, busy}, 2'b10);
    check("sp_tick_count", tick_t.size(), 2);
    do_clear();

    // Zero timesteps: done pulse in cycle 1, no ticks.
    lat = '{5, 5, 5, 5}; clear_logs();
    kick(0, 0, t0);
    check("zero_done", {done, busy}, 2'b11);
    step();
    check("zero_after", {done, busy}, 2'b00);
    check("zero_no_tick", tick_t.size(), 0);

    // Abort during the second WAIT, then restart, then reset mid-run.
    clear_logs();
    kick(2, 0, t0);
    for (int i = 0; i < 30 && tick_t.size() < 2; i++) step();
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    check("ab_idle", busy, 1'b0);
    repeat (10) step();
    check("ab_no_done", done_t.size(), 0);
    kick(2, 0, t0);
    check("ab_restart", {grid_tick, active_grid, timestep}, {4'b0001, 2'd0, 16'd0});
    repeat (20) step();
    reset_n = 1'b0; step();
    check("mr_cleared", {grid_tick, busy, active_grid, timestep, done, error, err_code}, 27'd0);
    reset_n = 1'b1; clear_logs();
    repeat (20) step();
    check("mr_quiet", tick_t.size() + done_t.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
